// File: rtl/mem_lsu_pkg.sv
// Shared size encodings, FSM state type and lane helpers for the mem_lsu load/store unit.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // A half at offset 3 shifts its upper byte off the 4-bit mask and is dropped.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Execute-side request/response handshakes plus the DRAM responder port of mem_lsu.
interface mem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        dram_en;
  logic        dram_wen;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wmask;
  logic [31:0] dram_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    output resp_ready, dram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dram_en, dram_wen, dram_addr, dram_wdata, dram_wmask
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    input  resp_ready, dram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dram_en, dram_wen, dram_addr, dram_wdata, dram_wmask
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store replication and byte mask, load shift and sign/zero extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        zext,
  input  logic [31:0] store_data,
  output logic [31:0] lane_data,
  output logic [3:0]  mask,
  input  logic [31:0] mem_data,
  output logic [31:0] load_data
);

  logic [15:0] sh;

  assign mask = lane_mask(size, off);
  assign sh   = 16'(mem_data >> {off, 3'b000});

  always_comb begin
    case (size)
      SZ_B:    lane_data = {4{store_data[7:0]}};
      SZ_H:    lane_data = {2{store_data[15:0]}};
      default: lane_data = store_data;
    endcase
  end

  // Word and reserved sizes read the whole word regardless of offset.
  always_comb begin
    case (size)
      SZ_B:    load_data = zext ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_data = zext ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_data = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a single-cycle DRAM responder; one request in flight at a time.
// Optional misalignment trapping is enabled with `define LSU_MISALIGN_CHECK_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_lsu_if.slave bus
);

  state_t      state;
  state_t      state_nxt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic [31:0] wdata_q;
  logic [3:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic [31:0] lane_data;
  logic [31:0] load_data;
  logic [3:0]  wmask;
  logic        req_fire;
  logic        resp_fire;
  logic        bad_req;

  assign req_fire  = (state == IDLE) && bus.req_valid;
  assign resp_fire = (state == RESP) && bus.resp_ready;

  mem_lsu_align u_align (
    .size       (size_q),
    .off        (addr_q[1:0]),
    .zext       (zext_q),
    .store_data (wdata_q),
    .lane_data  (lane_data),
    .mask       (wmask),
    .mem_data   (bus.dram_rdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_nxt = bad_req ? RESP : ACCESS;
      end
      ACCESS: begin
        if (wen_q || (wait_cnt == 4'd0)) state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter only runs for loads; stores leave ACCESS after one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q    <= 1'b0;
      addr_q   <= '0;
      size_q   <= SZ_B;
      zext_q   <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else if (req_fire) begin
      wen_q    <= bus.req_wen;
      addr_q   <= bus.req_addr;
      size_q   <= bus.req_size;
      zext_q   <= bus.req_unsigned;
      wdata_q  <= bus.req_wdata;
      wait_cnt <= 4'(RD_WAIT - 1);
      rdata_q  <= '0;
    end else if ((state == ACCESS) && !wen_q) begin
      if (wait_cnt == 4'd0) rdata_q  <= load_data;
      else                  wait_cnt <= wait_cnt - 4'd1;
    end else if (resp_fire) begin
      rdata_q <= '0;
    end
  end

  // Gating with rst_n keeps a reset during ACCESS from committing a write.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.dram_en    = 1'b0;
    bus.dram_wen   = 1'b0;
    bus.dram_addr  = '0;
    bus.dram_wdata = '0;
    bus.dram_wmask = '0;
    case (state)
      IDLE:   bus.req_ready = rst_n;
      ACCESS: begin
        if (rst_n) begin
          bus.dram_en    = 1'b1;
          bus.dram_wen   = wen_q;
          bus.dram_addr  = {addr_q[31:2], 2'b00};
          bus.dram_wdata = lane_data;
          bus.dram_wmask = wen_q ? wmask : 4'h0;
        end
      end
      RESP:   bus.resp_valid = rst_n;
      default: ;
    endcase
  end

  assign bus.resp_rdata = rst_n ? rdata_q : 32'h0;

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  assign bad_req = misaligned(bus.req_size, bus.req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (req_fire)  err_q <= bad_req;
    else if (resp_fire) err_q <= 1'b0;
  end

  assign bus.resp_err = err_q & bus.resp_valid;
`else
  assign bad_req      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a response scoreboard plus per-scenario lane, latency and reset checks.
`timescale 1ns/1ps
module tb_mem_lsu;

  localparam int unsigned RD_WAIT = 3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          n_writes = 0;
  exp_t        sb[$];
  exp_t        sb_head;
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;

  localparam logic [31:0] LD_ADDR [6] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0000,
                                          32'h8000_0003, 32'h8000_0003, 32'h8000_0001};
  localparam logic [1:0]  LD_SIZE [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic        LD_UNS  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] LD_EXP  [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_1234,
                                          32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0012};

  localparam logic [31:0] ST_ADDR [4] = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0012, 32'h8000_0014};
  localparam logic [1:0]  ST_SIZE [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
  localparam logic [31:0] ST_DATA [4] = '{32'h1234_5678, 32'h0000_00FF, 32'hCAFE_BEEF, 32'hA5A5_0F0F};
  localparam logic [3:0]  ST_MASK [4] = '{4'b0001, 4'b0010, 4'b1100, 4'b1111};
  localparam logic [31:0] ST_LANE [4] = '{32'h7878_7878, 32'hFFFF_FFFF, 32'hBEEF_BEEF, 32'hA5A5_0F0F};
  localparam int          ST_IDX  [4] = '{4, 4, 4, 5};
  localparam logic [31:0] ST_MEM  [4] = '{32'h0000_0078, 32'h0000_FF78, 32'hBEEF_FF78, 32'hA5A5_0F0F};

  mem_lsu_if bus();

  mem_lsu #(.RD_WAIT(RD_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-masked memory model; preloaded once on the first edge so later resets never reload it.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h8001_1234;
      mem[1]    <= 32'hDEAD_BEEF;
      mem[2]    <= 32'h5555_5555;
      mem_ready <= 1'b1;
    end else if (bus.dram_en && bus.dram_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus.dram_wmask[b]) mem[bus.dram_addr[7:2]][8*b +: 8] <= bus.dram_wdata[8*b +: 8];
      n_writes <= n_writes + 1;
    end
  end

  assign bus.dram_rdata = mem[bus.dram_addr[7:2]];

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL sb_unexpected: got rdata=%h err=%b, required no response", bus.resp_rdata, bus.resp_err);
      end else begin
        sb_head = sb.pop_front();
        if (bus.resp_rdata !== sb_head.rdata || bus.resp_err !== sb_head.err) begin
          n_bad++;
          $display("[TB] FAIL sb_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                   bus.resp_rdata, bus.resp_err, sb_head.rdata, sb_head.err);
        end
      end
    end
  end

  task automatic send(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_wen      = wen;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL req_accept: req_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk); #1;
    hs_cyc        = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.dram_en, bus.dram_wen} !== 5'b0 ||
        bus.resp_rdata !== 32'h0 || bus.dram_addr !== 32'h0 || bus.dram_wdata !== 32'h0 || bus.dram_wmask !== 4'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: rdy=%b vld=%b err=%b en=%b wen=%b rdata=%h addr=%h wmask=%h, required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.dram_en, bus.dram_wen, bus.resp_rdata,
               bus.dram_addr, bus.dram_wmask);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_idle_ready: got %b, required 1", bus.req_ready);
    end
  endtask

  task automatic wait_load(input logic [31:0] exp_addr, input string name);
    int en_cnt, lat;
    logic bad_bus;
    en_cnt = 0; lat = -1; bad_bus = 1'b0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.dram_en) begin
        en_cnt++;
        if (bus.dram_wen !== 1'b0 || bus.dram_addr !== exp_addr) bad_bus = 1'b1;
      end
      if (bus.resp_valid) lat = cyc - hs_cyc + 1;
    end
    n_cmp++;
    if (en_cnt != RD_WAIT || lat != 1 + RD_WAIT || bad_bus) begin
      n_bad++;
      $display("[TB] FAIL %s_timing: en_cycles=%0d resp_at=N+%0d bus_err=%b, required en_cycles=%0d resp_at=N+%0d bus_err=0",
               name, en_cnt, lat, bad_bus, RD_WAIT, 1 + RD_WAIT);
    end
  endtask

  task automatic test_load_ext();
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{rdata: LD_EXP[k], err: 1'b0});
      send(1'b0, LD_ADDR[k], LD_SIZE[k], LD_UNS[k], 32'h0);
      wait_load({LD_ADDR[k][31:2], 2'b00}, "load_ext");
    end
  endtask

  task automatic test_load_word();
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    send(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0);
    wait_load(32'h8000_0004, "load_word");
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    send(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.dram_en !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL misalign_trap: en=%b vld=%b err=%b, required en=0 vld=1 err=1",
               bus.dram_en, bus.resp_valid, bus.resp_err);
    end
`else
    sb.push_back('{rdata: 32'h8001_1234, err: 1'b0});
    send(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
    wait_load(32'h8000_0000, "misalign_word");
`endif
  endtask

  task automatic test_store_byte();
    int w0;
    w0 = n_writes;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    send(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_00AB);
    @(negedge clk);
    n_cmp++;
    if (bus.dram_en !== 1'b1 || bus.dram_wen !== 1'b1 || bus.dram_addr !== 32'h8000_0000 ||
        bus.dram_wmask !== 4'b1000 || bus.dram_wdata !== 32'hABAB_ABAB || bus.req_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL store_byte_bus: en=%b wen=%b addr=%h wmask=%b wdata=%h rdy=%b, required 1 1 80000000 1000 abababab 0",
               bus.dram_en, bus.dram_wen, bus.dram_addr, bus.dram_wmask, bus.dram_wdata, bus.req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.dram_en !== 1'b0 || bus.resp_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL store_byte_resp: en=%b vld=%b at N+2, required en=0 vld=1", bus.dram_en, bus.resp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (mem[0] !== 32'hAB01_1234 || n_writes != w0 + 1) begin
      n_bad++;
      $display("[TB] FAIL store_byte_mem: mem=%h writes=%0d, required mem=ab011234 writes=%0d", mem[0], n_writes - w0, 1);
    end
  endtask

  task automatic test_store_lanes();
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, ST_ADDR[k], ST_SIZE[k], 1'b0, ST_DATA[k]);
      @(negedge clk);
      n_cmp++;
      if (bus.dram_en !== 1'b1 || bus.dram_wen !== 1'b1 || bus.dram_addr !== {ST_ADDR[k][31:2], 2'b00} ||
          bus.dram_wmask !== ST_MASK[k] || bus.dram_wdata !== ST_LANE[k]) begin
        n_bad++;
        $display("[TB] FAIL store_lane_%0d: en=%b wen=%b addr=%h wmask=%b wdata=%h, required wmask=%b wdata=%h",
                 k, bus.dram_en, bus.dram_wen, bus.dram_addr, bus.dram_wmask, bus.dram_wdata, ST_MASK[k], ST_LANE[k]);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (mem[ST_IDX[k]] !== ST_MEM[k]) begin
        n_bad++;
        $display("[TB] FAIL store_mem_%0d: got %h, required %h", k, mem[ST_IDX[k]], ST_MEM[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    bus.resp_ready = 1'b0;
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    send(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.resp_valid;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("[TB] FAIL bp_resp_timeout: resp_valid=0 for 40 cycles, required 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEAD_BEEF || bus.req_ready !== 1'b0 || bus.dram_en !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL bp_hold_%0d: vld=%b rdata=%h rdy=%b en=%b, required 1 deadbeef 0 0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready, bus.dram_en);
      end
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL bp_release: vld=%b rdy=%b, required vld=0 rdy=1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_store();
    int w0;
    bit any_valid;
    w0 = n_writes;
    any_valid = 1'b0;
    send(1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.dram_en !== 1'b0 || bus.dram_wen !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rst_access_gate: en=%b wen=%b, required 0 0", bus.dram_en, bus.dram_wen);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rst_to_idle: req_ready=%b, required 1", bus.req_ready);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) any_valid = 1'b1;
    end
    n_cmp++;
    if (any_valid || mem[2] !== 32'h5555_5555 || n_writes != w0) begin
      n_bad++;
      $display("[TB] FAIL rst_no_commit: resp_seen=%b mem=%h writes=%0d, required 0 55555555 0",
               any_valid, mem[2], n_writes - w0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_ext();
    test_load_word();
    test_misalign();
    test_store_byte();
    test_store_lanes();
    test_backpressure();
    test_reset_mid_store();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
